decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_pkg.sv | 41 ++++
 rtl/decoder_if.sv | 47 ++++
 rtl/decoder_stats.sv | 40 ++++
 rtl/decoder.sv | 62 ++++++
 tb/tb_decoder.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Shared opcode encoding, control-word layout and the reference decode table.
// Used by the decoder RTL and by its testbench.
package decoder_pkg;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned NUM_OPS = 4;
    localparam int unsigned CTRL_W  = 6;

    typedef enum logic [OP_W-1:0] {
        OP_MULT = 2'b00,
        OP_NOP  = 2'b01,
        OP_ALU  = 2'b10,
        OP_BRAN = 2'b11
    } opcode_e;

    // Field order matches the documented control word, MSB first.
    typedef struct packed {
        logic bran;
        logic alu_flag;
        logic mult_flag;
        logic ram_flag;
        logic alu_ctrl;
        logic nw;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic ctrl_t decode_op(input opcode_e op);
        ctrl_t c;
        c = CTRL_IDLE;
        case (op)
            OP_MULT: c = 6'b001110;
            OP_NOP:  c = 6'b000000;
            OP_ALU:  c = 6'b010100;
            OP_BRAN: c = 6'b100001;
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decoder_if.sv
// Instruction/control bus between the issuing stage and the decoder.
// Statistics signals exist only when DECODER_STATS_EN is defined.
interface decoder_if #(
    parameter int unsigned CNT_W = 16
);
    import decoder_pkg::*;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("decoder_if: CNT_W must be at least 1");
    end

    logic            instr_valid;
    logic [OP_W-1:0] instruction;
    logic            out_valid;
    logic            bran;
    logic            alu_flag;
    logic            mult_flag;
    logic            ram_flag;
    logic            alu_ctrl;
    logic            nw;

`ifdef DECODER_STATS_EN
    logic                            stat_clr;
    logic [NUM_OPS-1:0][CNT_W-1:0]   stat_cnt;

    modport master (
        output instr_valid, instruction, stat_clr,
        input  out_valid, bran, alu_flag, mult_flag, ram_flag, alu_ctrl, nw, stat_cnt
    );

    modport slave (
        input  instr_valid, instruction, stat_clr,
        output out_valid, bran, alu_flag, mult_flag, ram_flag, alu_ctrl, nw, stat_cnt
    );
`else
    modport master (
        output instr_valid, instruction,
        input  out_valid, bran, alu_flag, mult_flag, ram_flag, alu_ctrl, nw
    );

    modport slave (
        input  instr_valid, instruction,
        output out_valid, bran, alu_flag, mult_flag, ram_flag, alu_ctrl, nw
    );
`endif

endinterface

// File: rtl/decoder_stats.sv
// Per-opcode saturating usage counters; clear wins over a same-cycle increment.
// Instantiated by the decoder only when DECODER_STATS_EN is defined.
module decoder_stats
    import decoder_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clr_i,
    input  logic                          inc_i,
    input  logic [OP_W-1:0]               op_i,
    output logic [NUM_OPS-1:0][CNT_W-1:0] cnt_o
);

    logic [NUM_OPS-1:0][CNT_W-1:0] cnt_q;
    logic [NUM_OPS-1:0][CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (clr_i) begin
                cnt_d[i] = '0;
            end else if (inc_i && (op_i == OP_W'(i)) && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/decoder.sv
// Two-bit opcode decoder with one-cycle registered control outputs.
// Optional per-opcode statistics counters are compiled in with DECODER_STATS_EN.
module decoder
    import decoder_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic     clk,
    input  logic     rst,
    decoder_if.slave dec_if
);

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("decoder: CNT_W must be at least 1");
    end

    ctrl_t ctrl_q;
    ctrl_t ctrl_d;
    logic  valid_q;
    logic  valid_d;

    // A bubble drives the same all-zero word as OP_NOP.
    always_comb begin
        valid_d = dec_if.instr_valid;
        ctrl_d  = CTRL_IDLE;
        if (dec_if.instr_valid) begin
            ctrl_d = decode_op(opcode_e'(dec_if.instruction));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= CTRL_IDLE;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign dec_if.out_valid = valid_q;
    assign dec_if.bran      = ctrl_q.bran;
    assign dec_if.alu_flag  = ctrl_q.alu_flag;
    assign dec_if.mult_flag = ctrl_q.mult_flag;
    assign dec_if.ram_flag  = ctrl_q.ram_flag;
    assign dec_if.alu_ctrl  = ctrl_q.alu_ctrl;
    assign dec_if.nw        = ctrl_q.nw;

`ifdef DECODER_STATS_EN
    decoder_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk   (clk),
        .rst   (rst),
        .clr_i (dec_if.stat_clr),
        .inc_i (dec_if.instr_valid),
        .op_i  (dec_if.instruction),
        .cnt_o (dec_if.stat_cnt)
    );
`endif

endmodule

// File: tb/tb_decoder.sv
// Scoreboard testbench for the decoder; stats checks run when DECODER_STATS_EN is defined.
module tb_decoder;
    import decoder_pkg::*;

`ifdef DECODER_STATS_EN
    localparam int unsigned CNT_W = 4;
`else
    localparam int unsigned CNT_W = 16;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    decoder_if #(.CNT_W(CNT_W)) dif ();

    decoder #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .dec_if (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] exp_q[$];
    int         exp_cnt[NUM_OPS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] observed();
        return {dif.out_valid, dif.bran, dif.alu_flag, dif.mult_flag,
                dif.ram_flag, dif.alu_ctrl, dif.nw};
    endfunction

    task automatic check_counts(input string tag);
`ifdef DECODER_STATS_EN
        for (int i = 0; i < NUM_OPS; i++) begin
            check($sformatf("%s_cnt%0d", tag, i), 32'(dif.stat_cnt[i]), 32'(exp_cnt[i]));
        end
`else
        return;
`endif
    endtask

    task automatic set_clr(input logic clr);
`ifdef DECODER_STATS_EN
        dif.stat_clr = clr;
`else
        if (clr) $display("note: stat_clr ignored in this build");
`endif
    endtask

    // Drive one cycle, push the expected output word, sample #1 after the edge and compare.
    task automatic step(input logic v, input logic [1:0] op, input logic clr,
                        input logic [6:0] exp, input string tag);
        dif.instr_valid = v;
        dif.instruction = op;
        set_clr(clr);
        exp_q.push_back(exp);
        for (int i = 0; i < NUM_OPS; i++) begin
            if (clr) exp_cnt[i] = 0;
            else if (v && (int'(op) == i) && (exp_cnt[i] < CNT_MAX)) exp_cnt[i]++;
        end
        @(posedge clk);
        #1;
        check(tag, 32'(observed()), 32'(exp_q.pop_front()));
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < NUM_OPS; i++) exp_cnt[i] = 0;
    endtask

    initial begin
        logic       v;
        logic [1:0] op;
        logic       clr;

        rst             = 1'b1;
        dif.instr_valid = 1'b1;
        dif.instruction = 2'b00;
        set_clr(1'b0);
        clear_model();

        // Held in reset across edges with a valid MULT on the bus.
        #22;
        check("reset_hold", 32'(observed()), 32'h0);
        check_counts("reset_hold");

        @(negedge clk);
        rst = 1'b0;

        // First valid edge after reset release decodes; full table sweep back to back.
        step(1'b1, 2'b00, 1'b0, 7'b1_001110, "sweep_mult");
        step(1'b1, 2'b01, 1'b0, 7'b1_000000, "sweep_nop");
        step(1'b1, 2'b10, 1'b0, 7'b1_010100, "sweep_alu");
        step(1'b1, 2'b11, 1'b0, 7'b1_100001, "sweep_bran");

        // Bubble with a BRAN opcode on the bus, then a valid decode again.
        step(1'b0, 2'b11, 1'b0, 7'b0, "bubble");
        step(1'b1, 2'b10, 1'b0, 7'b1_010100, "after_bubble");
        check_counts("sweep");

        // Asynchronous reset with nonzero outputs, no clock edge in between.
        step(1'b1, 2'b00, 1'b0, 7'b1_001110, "pre_reset");
        dif.instr_valid = 1'b1;
        dif.instruction = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 32'(observed()), 32'h0);
        clear_model();
        check_counts("async_reset");
        @(posedge clk);
        #1;
        check("reset_discard", 32'(observed()), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 2'b11, 1'b0, 7'b1_100001, "first_after_reset");

        // Random opcodes and valids against the package table.
        for (int n = 0; n < 1000; n++) begin
            v   = 1'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            clr = ($urandom_range(0, 63) == 0);
            step(v, op, clr, v ? {1'b1, decode_op(opcode_e'(op))} : 7'b0, "random");
        end
        check_counts("random");

`ifdef DECODER_STATS_EN
        step(1'b0, 2'b00, 1'b1, 7'b0, "stats_clear");
        check_counts("stats_clear");
        for (int n = 0; n < 20; n++) begin
            step(1'b1, 2'b10, 1'b0, 7'b1_010100, "stats_fill");
        end
        check("stats_sat_alu", 32'(dif.stat_cnt[2]), 32'd15);
        check_counts("stats_sat");
        step(1'b1, 2'b10, 1'b1, 7'b1_010100, "stats_clr_prio");
        check("stats_clr_alu", 32'(dif.stat_cnt[2]), 32'd0);
        check_counts("stats_clr_prio");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
